// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the PISO serial transmitter.
// State encoding and counter sizing helper.
package piso_serial_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int w);
    int r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/piso_serial_tx_dff_ar.sv
// Single-bit D flip-flop, asynchronous active-high reset to 0.
// Every state bit of the transmitter is built from this cell.
module dff_ar (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) Q <= 1'b0;
    else     Q <= D;
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter, MSB first, ready/load handshake.
// Last bit cycle reopens READY so words can run back-to-back.
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             DONE
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  logic             state_q;
  logic             state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  logic shifting;
  logic last;
  logic accept;

  dff_ar u_state (
    .CLK (CLK),
    .RST (RST),
    .D   (state_d),
    .Q   (state_q)
  );

  for (genvar i = 0; i < CW; i++) begin : g_cnt
    dff_ar u_ff (
      .CLK (CLK),
      .RST (RST),
      .D   (cnt_d[i]),
      .Q   (cnt_q[i])
    );
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_sr
    dff_ar u_ff (
      .CLK (CLK),
      .RST (RST),
      .D   (sr_d[i]),
      .Q   (sr_q[i])
    );
  end

  assign shifting = (state_q == SHIFT);
  assign last     = shifting && (cnt_q == '0);
  assign accept   = LOAD && READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = CNT_TOP;
      sr_d    = DIN;
    end else if (shifting) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
      if (last) state_d = IDLE;
      else      cnt_d   = cnt_q - CW'(1);
    end
  end

  // Outputs decode registered state only; LOAD/DIN never reach them.
  assign READY  = !shifting || last;
  assign SVALID = shifting;
  assign SOUT   = shifting && sr_q[WIDTH-1];
  assign DONE   = last;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx at WIDTH 8, 2 and 32.
// Word-level model checked every cycle plus literal stream checks.
module tb_piso_serial_tx;

  localparam int W [3] = '{8, 2, 32};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  load = '0;
  logic [31:0] din [3];
  logic [2:0]  ready, sout, svalid, done;

  int nchk = 0;
  int nerr = 0;

  int          rem  [3];
  logic [31:0] word [3];

  logic [63:0] cap [3];
  logic [63:0] dnv [3];
  int ncap [3];
  int ndone [3];
  int run [3];
  int maxrun [3];

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(8)) u_w8 (
    .CLK(clk), .RST(rst), .DIN(din[0][7:0]), .LOAD(load[0]),
    .READY(ready[0]), .SOUT(sout[0]), .SVALID(svalid[0]), .DONE(done[0])
  );

  piso_serial_tx #(.WIDTH(2)) u_w2 (
    .CLK(clk), .RST(rst), .DIN(din[1][1:0]), .LOAD(load[1]),
    .READY(ready[1]), .SOUT(sout[1]), .SVALID(svalid[1]), .DONE(done[1])
  );

  piso_serial_tx #(.WIDTH(32)) u_w32 (
    .CLK(clk), .RST(rst), .DIN(din[2]), .LOAD(load[2]),
    .READY(ready[2]), .SOUT(sout[2]), .SVALID(svalid[2]), .DONE(done[2])
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each word is WIDTH bit-slots; rem = slots still to send.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        rem[d] = 0;
      end else begin
        bit acc;
        acc = load[d] && (rem[d] <= 1);
        if (rem[d] > 0) rem[d]--;
        if (acc) begin
          word[d] = din[d];
          rem[d]  = W[d];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic [3:0] e;
      if (rst || rem[d] == 0) e = 4'b0001;
      else e = {word[d][rem[d]-1], 1'b1, rem[d] == 1, rem[d] == 1};
      chk($sformatf("cyc%0d sout,svalid,done,ready", W[d]),
          {60'd0, sout[d], svalid[d], done[d], ready[d]}, {60'd0, e});
      if (svalid[d]) begin
        cap[d] = {cap[d][62:0], sout[d]};
        dnv[d] = {dnv[d][62:0], done[d]};
        ncap[d]++;
        run[d]++;
        if (run[d] > maxrun[d]) maxrun[d] = run[d];
      end else begin
        run[d] = 0;
      end
      if (done[d]) ndone[d]++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr(input int d);
    cap[d] = '0; dnv[d] = '0;
    ncap[d] = 0; ndone[d] = 0;
    run[d] = 0; maxrun[d] = 0;
  endtask

  task automatic send(input int d, input logic [31:0] v);
    load[d] = 1'b1;
    din[d]  = v;
    step();
    load[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      din[d] = '0; rem[d] = 0; word[d] = '0;
      clr(d);
    end
    repeat (3) step();
    chk("reset outs", {60'd0, sout[0], svalid[0], done[0], ready[0]}, 64'h1);
    rst = 1'b0;
    repeat (3) step();
    chk("idle after reset", {63'd0, svalid[0]}, 64'd0);

    clr(0);
    send(0, 32'hA5);
    repeat (10) step();
    chk("A5 stream", cap[0], 64'hA5);
    chk("A5 count", 64'(ncap[0]), 64'd8);
    chk("A5 done pos", dnv[0], 64'h01);
    chk("A5 idle", {63'd0, svalid[0]}, 64'd0);

    clr(0);
    send(0, 32'hFF);
    repeat (7) step();
    load[0] = 1'b1;
    din[0]  = 32'h00;
    step();
    load[0] = 1'b0;
    repeat (12) step();
    chk("b2b stream", cap[0], 64'hFF00);
    chk("b2b run", 64'(maxrun[0]), 64'd16);
    chk("b2b done pos", dnv[0], 64'h0101);

    clr(0);
    send(0, 32'hC3);
    repeat (2) step();
    load[0] = 1'b1;
    din[0]  = 32'h0F;
    step();
    load[0] = 1'b0;
    repeat (12) step();
    chk("ignored stream", cap[0], 64'hC3);
    chk("ignored count", 64'(ncap[0]), 64'd8);
    chk("ignored dones", 64'(ndone[0]), 64'd1);

    clr(0);
    send(0, 32'h5A);
    repeat (3) step();
    #1 rst = 1'b1;
    #1;
    chk("rst async outs",
        {60'd0, sout[0], svalid[0], done[0], ready[0]}, 64'h1);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("abort bits", cap[0], 64'h5);
    chk("abort count", 64'(ncap[0]), 64'd4);
    chk("abort no done", 64'(ndone[0]), 64'd0);
    clr(0);
    send(0, 32'h81);
    repeat (10) step();
    chk("81 stream", cap[0], 64'h81);
    chk("81 count", 64'(ncap[0]), 64'd8);

    clr(1);
    send(1, 32'h2);
    repeat (4) step();
    chk("w2 stream", cap[1], 64'h2);
    chk("w2 count", 64'(ncap[1]), 64'd2);
    chk("w2 done pos", dnv[1], 64'h1);

    clr(2);
    send(2, 32'h8000_0001);
    repeat (34) step();
    chk("w32 stream", cap[2], 64'h8000_0001);
    chk("w32 count", 64'(ncap[2]), 64'd32);
    chk("w32 done pos", dnv[2], 64'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/piso_serial_tx.md
# piso_serial_tx

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a ready/load handshake and shifts it out MSB-first, one bit per CLK rising edge, with a bit-valid strobe and an end-of-word pulse. It is the transmit end of the serial bit link whose receive end captures bits with D flip-flops. All state is held in edge-triggered flip-flops with asynchronous reset.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- DIN  input  WIDTH  parallel word; sampled only on an accepted load.
- LOAD  input  1  load request; accepted at a rising edge where LOAD=1 and READY=1.
- READY  output  1  transmitter can accept a word at the next rising edge.
- SOUT  output  1  serial data, MSB first.
- SVALID  output  1  SOUT carries a valid bit this cycle.
- DONE  output  1  one-cycle pulse, high during the last bit of a word.

## Operation
- States: IDLE, SHIFT.
- Reset values (RST=1, effective immediately, no clock needed): state=IDLE, shift register=0, bit counter=0, SOUT=0, SVALID=0, DONE=0, READY=1.
- IDLE: READY=1, SVALID=0, SOUT=0, DONE=0. On an accepted load: shift register<=DIN, counter<=WIDTH-1, go to SHIFT.
- SHIFT: SVALID=1, SOUT=shift register MSB. Each edge: shift left by one (zero-fill), counter decrements.
- Last bit: counter==0. In this cycle DONE=1 and READY=1.
  - If LOAD=1 at the closing edge: reload from DIN, counter<=WIDTH-1, stay in SHIFT. Back-to-back words are sent with no idle gap.
  - Otherwise go to IDLE.
- LOAD while READY=0: ignored, with no effect on state or DIN sampling.
- DIN changes while SHIFT is in progress have no effect.
- Counter width is clog2(WIDTH). The counter never underflows because it is reloaded or cleared at 0.
- RST asserted mid-word: the word is aborted, all outputs take their reset values at once, and no DONE is produced. After RST deasserts, the first edge may accept a load.
- All outputs are registered or decoded from registered state only. No combinational path runs from LOAD or DIN to any output.

## Timing
- Load latency: a load accepted at edge k puts DIN[WIDTH-1] on SOUT with SVALID=1 from edge k until edge k+1.
- Bit i (MSB=0) is valid from edge k+i to edge k+i+1. A word occupies exactly WIDTH cycles of SVALID.
- DONE and READY are high during the cycle between edges k+WIDTH-1 and k+WIDTH.
- Sustained throughput is 1 bit per cycle. The minimum gap between words is 0 cycles.
- The downstream receiver samples SOUT on the CLK rising edge when SVALID=1. SOUT is stable for the full cycle.

## Structure
- Shared package: the state encoding constants (IDLE=1'b0, SHIFT=1'b1) and a function returning the counter width (clog2 of WIDTH, minimum 1).
- One sub-module: dff_ar, a single-bit D flip-flop with asynchronous active-high reset to 0 (ports CLK, RST, D, Q).
  - Instantiate it for the state bit, each counter bit, and each shift-register bit.
  - The top level holds only next-state and output logic.

## Test plan
- Reset: assert RST mid-simulation between edges. SOUT, SVALID and DONE go to 0 and READY goes to 1 before the next edge. After release, holding LOAD=0 keeps the block in IDLE.
- Single word, WIDTH=8: DIN=8'hA5, LOAD for one cycle.
  - SOUT over 8 SVALID cycles is 1,0,1,0,0,1,0,1.
  - DONE is high only in cycle 8. READY is 0 in cycles 1–7 and 1 in cycle 8.
  - The design returns to IDLE in cycle 9.
- Back-to-back: load 8'hFF, then hold LOAD=1 with DIN=8'h00 during the DONE cycle. SVALID stays high for 16 consecutive cycles, giving eight 1s then eight 0s. DONE pulses in cycles 8 and 16.
- Ignored load: pulse LOAD with DIN=8'h0F during cycle 3 of an 8'hC3 transfer. Output is still 1,1,0,0,0,0,1,1 and no extra word follows.
- Reset mid-word: assert RST in bit 4 of 8'h5A. Outputs clear immediately and DONE is never seen. A fresh load of 8'h81 after release sends 1,0,0,0,0,0,0,1.
- Parameter sweep: WIDTH=2 with DIN=2'b10 sends 1,0 with DONE in cycle 2. WIDTH=32 with DIN=32'h8000_0001 sends 1, then 30 zeros, then 1.
